// File: rtl/fetch_seq_pkg.sv
// Shared types and PC-select encoding for the fetch sequencer.
package fetch_seq_pkg;

  // Two-phase CPU sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } fetch_state_e;

  // PC-select codes; same encoding as control_logic's PS output.
  localparam logic [1:0] PS_HALT = 2'b00;
  localparam logic [1:0] PS_NEXT = 2'b01;
  localparam logic [1:0] PS_JUMP = 2'b10;
  localparam logic [1:0] PS_RET  = 2'b11;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the sequencer's control, instruction-memory and PC signals.
interface fetch_sequencer_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OFF_W = 8
);
  logic             start;
  logic             imem_ready;
  logic [1:0]       ps;
  logic             mp;
  logic [OFF_W-1:0] offset;
  logic             cpu_state;
  logic             imem_req;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  link_pc;
  logic             halted;
  logic             fault;

  // Sequencer side.
  modport master (
    input  start, imem_ready, ps, mp, offset,
    output cpu_state, imem_req, pc, link_pc, halted, fault
  );

  // Environment side (memory, control_logic, register file).
  modport slave (
    output start, imem_ready, ps, mp, offset,
    input  cpu_state, imem_req, pc, link_pc, halted, fault
  );
endinterface

// File: rtl/fetch_sequencer_return_stack.sv
// Return-address LIFO; push on full and pop on empty are ignored here and
// reported as faults by the sequencer.
module return_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int unsigned SPW  = $clog2(DEPTH) + 1;
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0]   sp_q, sp_d, sp_m1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign sp_m1 = sp_q - SPW'(1);
  assign empty = (sp_q == '0);
  assign full  = (sp_q == SPW'(DEPTH));
  assign dout  = mem_q[sp_m1[IDXW-1:0]];

  // Next stack pointer and entry contents.
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full) begin
      mem_d[sp_q[IDXW-1:0]] = din;
      sp_d                  = sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_m1;
    end
  end

  // Stack pointer register; reset empties the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage; contents are don't-care while not covered by the pointer.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch/execute sequencing with a call/return stack.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned OFF_W     = 8,
  parameter int unsigned STK_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.master bus
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] link_pc;
  logic            stk_push, stk_pop, stk_clr;
  logic [PC_W-1:0] stk_top;
  logic            stk_empty, stk_full;

  // Offset is two's complement: sign-extend when narrower, truncate otherwise.
  if (OFF_W >= PC_W) begin : g_off_trunc
    always_comb off_ext = bus.offset[PC_W-1:0];
  end else begin : g_off_sext
    always_comb off_ext = {{(PC_W - OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
  end

  assign link_pc = pc_q + PC_W'(1);

  return_stack #(
    .WIDTH(PC_W),
    .DEPTH(STK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst || stk_clr),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (link_pc),
    .dout (stk_top),
    .empty(stk_empty),
    .full (stk_full)
  );

  // Next-state, PC update and stack control.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fault_d  = fault_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StFetch;
      end
      StFetch: begin
        if (bus.imem_ready) state_d = StExec;
      end
      StExec: begin
        unique case (bus.ps)
          PS_NEXT: begin
            pc_d    = link_pc;
            state_d = StFetch;
          end
          PS_JUMP: begin
            if (bus.mp && stk_full) begin
              fault_d = 1'b1;
              state_d = StHalt;
            end else begin
              stk_push = bus.mp;
              pc_d     = pc_q + off_ext;
              state_d  = StFetch;
            end
          end
          PS_RET: begin
            if (stk_empty) begin
              fault_d = 1'b1;
              state_d = StHalt;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
              state_d = StFetch;
            end
          end
          default: state_d = StHalt;
        endcase
      end
      StHalt: begin
        if (bus.start) begin
          pc_d    = '0;
          fault_d = 1'b0;
          stk_clr = 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign bus.cpu_state = (state_q == StExec);
  assign bus.imem_req  = (state_q == StFetch);
  assign bus.halted    = (state_q == StHalt);
  assign bus.fault     = fault_q;
  assign bus.pc        = pc_q;
  assign bus.link_pc   = link_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  fetch_sequencer_if #(.PC_W(8), .OFF_W(8)) bus ();

  fetch_sequencer #(
    .PC_W     (8),
    .OFF_W    (8),
    .STK_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus.start      = 1'b0;
    bus.imem_ready = 1'b1;
    bus.ps         = 2'b01;
    bus.mp         = 1'b0;
    bus.offset     = '0;
    rst            = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // From FETCH with ready high: go to EXEC, present ps/mp/offset, take closing edge.
  task automatic exec_instr(input logic [1:0] p, input logic m, input logic [7:0] o);
    tick();
    bus.ps     = p;
    bus.mp     = m;
    bus.offset = o;
    tick();
    bus.ps     = 2'b01;
    bus.mp     = 1'b0;
    bus.offset = '0;
  endtask

  task automatic test_reset();
    reset_dut();
    vecs++; if (bus.cpu_state !== 1'b0) begin errs++; $display("FAIL rst_cpu_state got %b exp 0", bus.cpu_state); end
    vecs++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL rst_imem_req got %b exp 0", bus.imem_req); end
    vecs++; if (bus.pc !== 8'd0) begin errs++; $display("FAIL rst_pc got %0d exp 0", bus.pc); end
    vecs++; if (bus.halted !== 1'b0) begin errs++; $display("FAIL rst_halted got %b exp 0", bus.halted); end
    vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL rst_fault got %b exp 0", bus.fault); end
    tick();
    vecs++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL idle_hold got %b exp 0", bus.imem_req); end
  endtask

  task automatic test_sequential();
    reset_dut();
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      vecs++; if (bus.pc !== 8'(i)) begin errs++; $display("FAIL seq_pc[%0d] got %0d exp %0d", i, bus.pc, i); end
      vecs++; if ({bus.cpu_state, bus.imem_req} !== 2'b01) begin
        errs++; $display("FAIL seq_fetch[%0d] got st/req %b exp 01", i, {bus.cpu_state, bus.imem_req});
      end
      tick();
      vecs++; if ({bus.cpu_state, bus.imem_req} !== 2'b10) begin
        errs++; $display("FAIL seq_exec[%0d] got st/req %b exp 10", i, {bus.cpu_state, bus.imem_req});
      end
      bus.ps = 2'b01;
      tick();
    end
    vecs++; if (bus.pc !== 8'd4) begin errs++; $display("FAIL seq_pc_end got %0d exp 4", bus.pc); end
  endtask

  task automatic test_jump();
    reset_dut();
    start_pulse();
    for (int i = 0; i < 5; i++) exec_instr(2'b01, 1'b0, 8'h00);
    vecs++; if (bus.pc !== 8'd5) begin errs++; $display("FAIL jmp_pre got %0d exp 5", bus.pc); end
    exec_instr(2'b10, 1'b0, 8'hFD);
    vecs++; if (bus.pc !== 8'd2) begin errs++; $display("FAIL jmp_back got %0d exp 2", bus.pc); end
    reset_dut();
    start_pulse();
    exec_instr(2'b10, 1'b0, 8'hFA);
    vecs++; if (bus.pc !== 8'd250) begin errs++; $display("FAIL jmp_250 got %0d exp 250", bus.pc); end
    exec_instr(2'b10, 1'b0, 8'd10);
    vecs++; if (bus.pc !== 8'd4) begin errs++; $display("FAIL jmp_wrap got %0d exp 4", bus.pc); end
    vecs++; if (bus.halted !== 1'b0) begin errs++; $display("FAIL jmp_wrap_halted got %b exp 0", bus.halted); end
    exec_instr(2'b10, 1'b0, 8'hFA);
    for (int i = 0; i < 5; i++) exec_instr(2'b01, 1'b0, 8'h00);
    vecs++; if (bus.pc !== 8'd3) begin errs++; $display("FAIL next_wrap got %0d exp 3", bus.pc); end
  endtask

  task automatic test_call_return();
    reset_dut();
    start_pulse();
    // mp with ps=01 must not push.
    exec_instr(2'b01, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) exec_instr(2'b01, 1'b0, 8'h00);
    vecs++; if (bus.pc !== 8'd3) begin errs++; $display("FAIL call_pre got %0d exp 3", bus.pc); end
    tick();
    vecs++; if (bus.link_pc !== 8'd4) begin errs++; $display("FAIL call_link got %0d exp 4", bus.link_pc); end
    bus.ps = 2'b10; bus.mp = 1'b1; bus.offset = 8'd4;
    tick();
    bus.ps = 2'b01; bus.mp = 1'b0; bus.offset = '0;
    vecs++; if (bus.pc !== 8'd7) begin errs++; $display("FAIL call_pc got %0d exp 7", bus.pc); end
    exec_instr(2'b01, 1'b0, 8'h00);
    exec_instr(2'b11, 1'b0, 8'h00);
    vecs++; if (bus.pc !== 8'd4) begin errs++; $display("FAIL ret_pc got %0d exp 4", bus.pc); end
    vecs++; if (bus.halted !== 1'b0) begin errs++; $display("FAIL ret_halted got %b exp 0", bus.halted); end
    // Stack must now be empty (and the mp-with-next above pushed nothing).
    exec_instr(2'b11, 1'b0, 8'h00);
    vecs++; if ({bus.halted, bus.fault} !== 2'b11) begin
      errs++; $display("FAIL ret_empty got halt/fault %b exp 11", {bus.halted, bus.fault});
    end
    vecs++; if (bus.pc !== 8'd4) begin errs++; $display("FAIL ret_empty_pc got %0d exp 4", bus.pc); end
  endtask

  task automatic test_overflow();
    reset_dut();
    start_pulse();
    for (int i = 0; i < 4; i++) exec_instr(2'b10, 1'b1, 8'd1);
    vecs++; if ({bus.pc, bus.halted} !== {8'd4, 1'b0}) begin
      errs++; $display("FAIL ovf_four got pc %0d halt %b exp 4 0", bus.pc, bus.halted);
    end
    exec_instr(2'b10, 1'b1, 8'd1);
    tick();
    tick();
    vecs++; if ({bus.halted, bus.fault} !== 2'b11) begin
      errs++; $display("FAIL ovf_fault got halt/fault %b exp 11", {bus.halted, bus.fault});
    end
    vecs++; if (bus.pc !== 8'd4) begin errs++; $display("FAIL ovf_pc got %0d exp 4", bus.pc); end
    vecs++; if ({bus.cpu_state, bus.imem_req} !== 2'b00) begin
      errs++; $display("FAIL ovf_outs got st/req %b exp 00", {bus.cpu_state, bus.imem_req});
    end
    // Restart clears fault, pc and the stack.
    start_pulse();
    vecs++; if ({bus.fault, bus.halted, bus.imem_req, bus.pc} !== {3'b001, 8'd0}) begin
      errs++; $display("FAIL ovf_restart got f/h/req %b pc %0d exp 001 0",
                       {bus.fault, bus.halted, bus.imem_req}, bus.pc);
    end
    exec_instr(2'b11, 1'b0, 8'h00);
    vecs++; if ({bus.halted, bus.fault} !== 2'b11) begin
      errs++; $display("FAIL ovf_stack_clr got halt/fault %b exp 11", {bus.halted, bus.fault});
    end
  endtask

  task automatic test_underflow();
    reset_dut();
    start_pulse();
    exec_instr(2'b11, 1'b0, 8'h00);
    vecs++; if ({bus.halted, bus.fault, bus.pc} !== {2'b11, 8'd0}) begin
      errs++; $display("FAIL unf got halt/fault %b pc %0d exp 11 0", {bus.halted, bus.fault}, bus.pc);
    end
  endtask

  task automatic test_ready_stall();
    reset_dut();
    bus.imem_ready = 1'b0;
    start_pulse();
    for (int i = 0; i < 3; i++) begin
      vecs++; if ({bus.imem_req, bus.cpu_state, bus.pc} !== {2'b10, 8'd0}) begin
        errs++; $display("FAIL stall[%0d] got req/st %b pc %0d exp 10 0", i,
                         {bus.imem_req, bus.cpu_state}, bus.pc);
      end
      tick();
    end
    bus.imem_ready = 1'b1;
    vecs++; if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL stall_rdy got %b exp 1", bus.imem_req); end
    tick();
    vecs++; if (bus.cpu_state !== 1'b1) begin errs++; $display("FAIL stall_exec got %b exp 1", bus.cpu_state); end
    tick();
    vecs++; if (bus.pc !== 8'd1) begin errs++; $display("FAIL stall_pc got %0d exp 1", bus.pc); end
  endtask

  task automatic test_halt_restart();
    reset_dut();
    start_pulse();
    exec_instr(2'b01, 1'b0, 8'h00);
    exec_instr(2'b01, 1'b0, 8'h00);
    exec_instr(2'b00, 1'b0, 8'h00);
    vecs++; if ({bus.halted, bus.fault, bus.pc} !== {2'b10, 8'd2}) begin
      errs++; $display("FAIL halt got halt/fault %b pc %0d exp 10 2", {bus.halted, bus.fault}, bus.pc);
    end
    start_pulse();
    vecs++; if ({bus.halted, bus.imem_req, bus.pc} !== {2'b01, 8'd0}) begin
      errs++; $display("FAIL restart got halt/req %b pc %0d exp 01 0", {bus.halted, bus.imem_req}, bus.pc);
    end
  endtask

  task automatic test_mid_fetch_reset();
    reset_dut();
    start_pulse();
    exec_instr(2'b01, 1'b0, 8'h00);
    exec_instr(2'b01, 1'b0, 8'h00);
    bus.imem_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if ({bus.imem_req, bus.cpu_state, bus.halted, bus.pc} !== {3'b000, 8'd0}) begin
      errs++; $display("FAIL midrst got req/st/halt %b pc %0d exp 000 0",
                       {bus.imem_req, bus.cpu_state, bus.halted}, bus.pc);
    end
    bus.imem_ready = 1'b1;
    tick();
    vecs++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL midrst_idle got %b exp 0", bus.imem_req); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_call_return();
    test_overflow();
    test_underflow();
    test_ready_stall();
    test_halt_restart();
    test_mid_fetch_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
